// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-Lite types and constants
// for the single-slave memory block.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // bytes moved by one beat of the given hsize
  function automatic logic [3:0] size_bytes(
    input logic [2:0] size
  );
    case (size)
      HSIZE_BYTE:  size_bytes = 4'd1;
      HSIZE_HALF:  size_bytes = 4'd2;
      HSIZE_WORD:  size_bytes = 4'd4;
      HSIZE_DWORD: size_bytes = 4'd8;
      default:     size_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// ahb_slave_mem_array: single-port byte-writable storage,
// synchronous write, combinational read.
module ahb_slave_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = DATA_W / 8
) (
  input  logic              clk,
  input  logic [NB-1:0]     be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // byte-lane writes; no reset so contents survive hresetn
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// ahb_lite_slave_mem: AHB-Lite memory slave with error path.
// Wait states compiled only with AHB_SLAVE_WAIT_STATES_EN.
module ahb_lite_slave_mem
  import ahb_lite_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              hclk_f,
  input  logic              hresetn_f,
  input  logic              hsel_f,
  input  logic [ADDR_W-1:0] haddr_f,
  input  logic [1:0]        htrans_f,
  input  logic              hwrite_f,
  input  logic [2:0]        hsize_f,
  input  logic [2:0]        hburst_f,
  input  logic [3:0]        hprot_f,
  input  logic [DATA_W-1:0] hwdata_f,
  input  logic              error_f,
  output logic [DATA_W-1:0] hrdata_f,
  output logic              hready_f,
  output logic              hresp_f
);

  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'(NB);
  localparam logic [2:0] SIZE_MAX =
    (DATA_W == 64) ? HSIZE_DWORD : HSIZE_WORD;

  slave_state_e      state;
  logic              ready;
  logic              resp;
  logic              write_q;
  logic [2:0]        size_q;
  logic [AW-1:0]     word_q;
  logic [OB-1:0]     off_q;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] rdata;
  logic [NB-1:0]     be;
  logic              accept;
  logic              bad;
  logic [7:0]        align_mask;
  logic              unused_ok;
`ifdef AHB_SLAVE_WAIT_STATES_EN
  logic [3:0]        cnt;
`endif

  assign unused_ok = ^{hburst_f, hprot_f, 4'(WAIT_CYCLES)};

  assign accept = hsel_f && ready &&
    (htrans_f == TRANS_NONSEQ || htrans_f == TRANS_SEQ);

  assign align_mask = 8'(size_bytes(hsize_f)) - 8'd1;

  assign bad = error_f
    || (64'(haddr_f) >= LIMIT)
    || (hsize_f > SIZE_MAX)
    || (|(haddr_f[7:0] & align_mask));

  // lanes of the data-phase write; killed by reset mid-beat
  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(off_q) &&
          i < int'(off_q) + int'(size_bytes(size_q)))
        be[i] = 1'b1;
    end
    if (state != ST_DATA || !write_q || !hresetn_f)
      be = '0;
  end

  ahb_slave_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (hclk_f),
    .be    (be),
    .addr  (word_q),
    .wdata (hwdata_f),
    .rdata (rdata)
  );

  // a preceding write commits before this read's data cycle,
  // so reading the array here gives write-before-read forwarding
  assign hrdata_f = (state == ST_DATA && !write_q) ? rdata : hold;
  assign hready_f = ready;
  assign hresp_f  = resp;

  // transfer sequencing and registered bus handshake
  always_ff @(posedge hclk_f) begin
    if (!hresetn_f) begin
      state   <= ST_IDLE;
      ready   <= 1'b1;
      resp    <= HRESP_OKAY;
      hold    <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      word_q  <= '0;
      off_q   <= '0;
`ifdef AHB_SLAVE_WAIT_STATES_EN
      cnt     <= '0;
`endif
    end else begin
      if (state == ST_DATA && !write_q) hold <= rdata;
      unique case (state)
        ST_ERR1: begin
          state <= ST_ERR2;
          ready <= 1'b1;
          resp  <= HRESP_ERROR;
        end
`ifdef AHB_SLAVE_WAIT_STATES_EN
        ST_WAIT: begin
          if (cnt == 4'(WAIT_CYCLES - 1)) begin
            state <= ST_DATA;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
`endif
        default: begin
          if (accept) begin
            write_q <= hwrite_f;
            size_q  <= hsize_f;
            word_q  <= haddr_f[OB +: AW];
            off_q   <= haddr_f[OB-1:0];
            if (bad) begin
              state <= ST_ERR1;
              ready <= 1'b0;
              resp  <= HRESP_ERROR;
            end
`ifdef AHB_SLAVE_WAIT_STATES_EN
            else if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
              ready <= 1'b0;
              resp  <= HRESP_OKAY;
              cnt   <= '0;
            end
`endif
            else begin
              state <= ST_DATA;
              ready <= 1'b1;
              resp  <= HRESP_OKAY;
            end
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
            resp  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// tb_ahb_lite_slave_mem: directed and random transfers
// against a byte-array model of the slave memory.
module tb_ahb_lite_slave_mem;

`ifdef AHB_SLAVE_WAIT_STATES_EN
  localparam int W_EXP = 3;
`else
  localparam int W_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn, w_rstn;
  logic        hsel, hwrite, err;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [31:0] hrdata, w_hrdata;
  logic        hready, hresp, w_hready, w_hresp;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [4096];

  always #5 clk = ~clk;

  ahb_lite_slave_mem #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(0)
  ) dut (
    .hclk_f(clk), .hresetn_f(rstn), .hsel_f(hsel),
    .haddr_f(haddr), .htrans_f(htrans), .hwrite_f(hwrite),
    .hsize_f(hsize), .hburst_f(hburst), .hprot_f(hprot),
    .hwdata_f(hwdata), .error_f(err), .hrdata_f(hrdata),
    .hready_f(hready), .hresp_f(hresp)
  );

  ahb_lite_slave_mem #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(3)
  ) dut_w (
    .hclk_f(clk), .hresetn_f(w_rstn), .hsel_f(hsel),
    .haddr_f(haddr), .htrans_f(htrans), .hwrite_f(hwrite),
    .hsize_f(hsize), .hburst_f(hburst), .hprot_f(hprot),
    .hwdata_f(hwdata), .error_f(err), .hrdata_f(w_hrdata),
    .hready_f(w_hready), .hresp_f(w_hresp)
  );

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & 'hFFC;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic void ref_write(
    input int a, input int sz, input logic [31:0] d
  );
    for (int k = 0; k < (1 << sz); k++)
      ref_mem[(a + k) & 4095] = d[8*((a + k) % 4) +: 8];
  endfunction

  // one isolated transfer; returns stall count and responses
  task automatic xfer(
    input bit w, input bit wr, input logic [31:0] a,
    input logic [2:0] sz, input logic [31:0] d, input bit e,
    output logic [31:0] rd, output int lows,
    output logic lr, output logic fr
  );
    hsel = 1'b1; htrans = 2'd2; hwrite = wr; haddr = a;
    hsize = sz; err = e; hwdata = $urandom();
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; err = 1'b0; hwdata = d;
    lows = 0; lr = 1'b0;
    while ((w ? w_hready : hready) !== 1'b1 && lows < 20) begin
      lr = lr | (w ? w_hresp : hresp);
      lows++;
      @(posedge clk); #1;
    end
    rd = w ? w_hrdata : hrdata;
    fr = w ? w_hresp : hresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; w_rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hready !== 1'b1) begin errors++;
      $display("FAIL reset_hready: got %b expected 1", hready); end
    checks++;
    if (hresp !== 1'b0) begin errors++;
      $display("FAIL reset_hresp: got %b expected 0", hresp); end
    checks++;
    if (hrdata !== 32'h0) begin errors++;
      $display("FAIL reset_hrdata: got %h expected 0", hrdata); end
    checks++;
    if (w_hready !== 1'b1 || w_hresp !== 1'b0) begin errors++;
      $display("FAIL reset_w_handshake: got %b/%b expected 1/0",
               w_hready, w_hresp); end
    rstn = 1'b1; w_rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [31:0] rd; int lows; logic lr, fr;
    xfer(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, rd, lows, lr, fr);
    ref_write('h10, 2, 32'hDEADBEEF);
    checks++;
    if (lows !== 0 || fr !== 1'b0) begin errors++;
      $display("FAIL single_wr: stalls=%0d resp=%b expected 0/0",
               lows, fr); end
    xfer(0, 0, 32'h10, 3'd2, 32'h0, 0, rd, lows, lr, fr);
    checks++;
    if (lows !== 0 || fr !== 1'b0) begin errors++;
      $display("FAIL single_rd: stalls=%0d resp=%b expected 0/0",
               lows, fr); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++;
      $display("FAIL single_data: got %h expected deadbeef", rd); end
    checks++;
    if (hrdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rdata_hold: got %h expected deadbeef", hrdata); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; int lows; logic lr, fr;
    xfer(0, 1, 32'h10, 3'd2, 32'h11223344, 0, rd, lows, lr, fr);
    ref_write('h10, 2, 32'h11223344);
    xfer(0, 1, 32'h13, 3'd0, 32'hAA000000, 0, rd, lows, lr, fr);
    ref_write('h13, 0, 32'hAA000000);
    xfer(0, 0, 32'h10, 3'd2, 32'h0, 0, rd, lows, lr, fr);
    checks++;
    if (rd !== 32'hAA223344) begin errors++;
      $display("FAIL byte_write: got %h expected aa223344", rd); end
    xfer(0, 1, 32'h14, 3'd2, 32'h55667788, 0, rd, lows, lr, fr);
    ref_write('h14, 2, 32'h55667788);
    xfer(0, 1, 32'h16, 3'd1, 32'hBEEF0000, 0, rd, lows, lr, fr);
    ref_write('h16, 1, 32'hBEEF0000);
    xfer(0, 0, 32'h14, 3'd2, 32'h0, 0, rd, lows, lr, fr);
    checks++;
    if (rd !== 32'hBEEF7788) begin errors++;
      $display("FAIL half_write: got %h expected beef7788", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] ea [5];
    logic [2:0]  es [5];
    bit          ei [5];
    logic [31:0] rd, old, tgt; int lows; logic lr, fr;
    ea = '{32'h1000, 32'h12, 32'h10, 32'h20, 32'h11};
    es = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd1};
    ei = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      tgt = ea[k] & 32'hFFC;
      old = $urandom();
      xfer(0, 1, tgt, 3'd2, old, 0, rd, lows, lr, fr);
      ref_write(int'(tgt), 2, old);
      xfer(0, 1, ea[k], es[k], ~old, ei[k], rd, lows, lr, fr);
      checks++;
      if (lows !== 1 || lr !== 1'b1) begin errors++;
        $display("FAIL err%0d_first: stalls=%0d resp=%b expected 1/1",
                 k, lows, lr); end
      checks++;
      if (fr !== 1'b1) begin errors++;
        $display("FAIL err%0d_second: resp=%b expected 1", k, fr); end
      xfer(0, 0, tgt, 3'd2, 32'h0, 0, rd, lows, lr, fr);
      checks++;
      if (rd !== ref_word(int'(tgt))) begin errors++;
        $display("FAIL err%0d_mem: got %h expected %h",
                 k, rd, ref_word(int'(tgt))); end
    end
  endtask

  task automatic test_back_to_back();
    logic        pend, pw;
    int          pa, ps, lows;
    logic [31:0] pd, rd, exp;
    logic        lr, fr;
    for (int a = 0; a < 256; a += 4) begin
      pd = $urandom();
      xfer(0, 1, 32'(a), 3'd2, pd, 0, rd, lows, lr, fr);
      ref_write(a, 2, pd);
    end
    pend = 1'b0; pw = 1'b0; pa = 0; ps = 0; pd = '0;
    for (int i = 0; i <= 200; i++) begin
      checks++;
      if (hready !== 1'b1 || hresp !== 1'b0) begin errors++;
        $display("FAIL b2b_hs[%0d]: got %b/%b expected 1/0",
                 i, hready, hresp); end
      if (pend && !pw) begin
        exp = ref_word(pa);
        checks++;
        if (hrdata !== exp) begin errors++;
          $display("FAIL b2b_rd[%0d] @%h: got %h expected %h",
                   i, pa, hrdata, exp); end
      end
      hwdata = (pend && pw) ? pd : $urandom();
      if (pend && pw) ref_write(pa, ps, pd);
      pend = (i < 200) && ($urandom_range(0, 3) != 0);
      hburst = 3'($urandom_range(0, 7));
      hprot  = 4'($urandom_range(0, 15));
      if (pend) begin
        pw = 1'($urandom_range(0, 1));
        ps = $urandom_range(0, 2);
        pa = $urandom_range(0, 255) & ~((1 << ps) - 1);
        pd = $urandom();
        hsel = 1'b1; err = 1'b0; hwrite = pw;
        htrans = $urandom_range(0, 1) ? 2'd2 : 2'd3;
        haddr = 32'(pa); hsize = 3'(ps);
      end else begin
        hsel = 1'($urandom_range(0, 1));
        htrans = hsel ? 2'($urandom_range(0, 1))
                      : 2'($urandom_range(0, 3));
        hwrite = 1'b1; err = 1'($urandom_range(0, 1));
        haddr = $urandom(); hsize = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
    end
    hsel = 1'b0; htrans = 2'd0;
  endtask

  task automatic test_wait();
    logic [31:0] rd; int lows; logic lr, fr;
    w_rstn = 1'b0;
    @(posedge clk); #1;
    w_rstn = 1'b1;
    xfer(1, 1, 32'h8, 3'd2, 32'hCAFEF00D, 0, rd, lows, lr, fr);
    ref_write('h8, 2, 32'hCAFEF00D);
    checks++;
    if (lows !== W_EXP || lr !== 1'b0) begin errors++;
      $display("FAIL wait_wr: stalls=%0d resp=%b expected %0d/0",
               lows, lr, W_EXP); end
    xfer(1, 0, 32'h8, 3'd2, 32'h0, 0, rd, lows, lr, fr);
    checks++;
    if (lows !== W_EXP || fr !== 1'b0) begin errors++;
      $display("FAIL wait_rd: stalls=%0d resp=%b expected %0d/0",
               lows, fr, W_EXP); end
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++;
      $display("FAIL wait_data: got %h expected cafef00d", rd); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd; int lows; logic lr, fr;
    xfer(1, 1, 32'h40, 3'd2, 32'h01234567, 0, rd, lows, lr, fr);
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h40;
    hsize = 3'd2; err = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h89ABCDEF;
    repeat ((W_EXP >= 2) ? 1 : 0) begin
      @(posedge clk); #1;
    end
    checks++;
    if (w_hready !== 1'(W_EXP == 0)) begin errors++;
      $display("FAIL rstw_pre: hready=%b expected %b",
               w_hready, W_EXP == 0); end
    w_rstn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (w_hready !== 1'b1 || w_hresp !== 1'b0) begin errors++;
      $display("FAIL rstw_hs: got %b/%b expected 1/0",
               w_hready, w_hresp); end
    w_rstn = 1'b1;
    xfer(1, 0, 32'h40, 3'd2, 32'h0, 0, rd, lows, lr, fr);
    ref_write('h40, 2, 32'h89ABCDEF);
    checks++;
    if (rd !== 32'h01234567) begin errors++;
      $display("FAIL rstw_mem: got %h expected 01234567", rd); end
  endtask

  task automatic test_reset_again();
    logic [31:0] rd; int lows; logic lr, fr;
    xfer(0, 0, 32'h10, 3'd2, 32'h0, 0, rd, lows, lr, fr);
    rstn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (hrdata !== 32'h0 || hready !== 1'b1) begin errors++;
      $display("FAIL rst2: hrdata=%h hready=%b expected 0/1",
               hrdata, hready); end
    rstn = 1'b1;
    xfer(0, 0, 32'h10, 3'd2, 32'h0, 0, rd, lows, lr, fr);
    checks++;
    if (rd !== ref_word('h10)) begin errors++;
      $display("FAIL rst2_mem: got %h expected %h",
               rd, ref_word('h10)); end
  endtask

  initial begin
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = '0;
    hsize = 3'd2; hburst = 3'd0; hprot = 4'h3; hwdata = '0;
    err = 1'b0;
    test_reset();
    test_single();
    test_byte();
    test_errors();
    test_back_to_back();
    test_wait();
    test_reset_wait();
    test_reset_again();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
